// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//
// Responder end of the data SRAM port driven by the EX stage. Holds a local
// word array with byte-lane writes and synchronous word reads. Read data is
// registered for the MEM stage. An optional wait-state FSM holds the pipeline
// through stallreq for WAIT_CYCLES cycles per access.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   BASE_ADDR    byte base of the decoded window, aligned to DEPTH*4
//   WAIT_CYCLES  stall cycles per access, 0..15 (0 = single-cycle SRAM)
//
// Ports
//   clk              clock, all state updates on posedge
//   resetn           synchronous reset, active low
//   data_sram_en     access request, held stable while stallreq=1
//   data_sram_wen    byte write enables, 4'b0000 = read
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data, lane i = bits [8i+7:8i]
//   data_sram_rdata  registered read data, valid the cycle after commit
//   stallreq         combinational hold request toward CTRL
//   addr_err         registered 1-cycle pulse for an out-of-window commit
//
// FSM states (only used when WAIT_CYCLES > 0)
//   state   | meaning
//   --------+----------------------------------------------------------------
//   ST_IDLE | no access in flight; a new en=1 starts the wait countdown
//   ST_WAIT | access pending; commits when cnt reaches 0 with en still high
// -----------------------------------------------------------------------------
module data_sram_resp #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic        addr_err
);

   localparam int AW = $clog2(DEPTH);

   // First countdown value loaded on entry to ST_WAIT. The WAIT_CYCLES==0
   // case never loads it, so it is pinned to 0 to keep the cast legal.
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic        commit;

   logic [31:0] mem [DEPTH];

   logic          in_range;
   logic [AW-1:0] index;
   logic          is_read;
   logic          commit_wr;
   logic          commit_rd;

   // Byte offset within the word carries no meaning for a word-wide array.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^data_sram_addr[1:0];

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   assign in_range = (data_sram_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign index    = data_sram_addr[AW+1:2];
   assign is_read  = (data_sram_wen == 4'b0000);

   assign commit_wr = commit && in_range && !is_read;
   assign commit_rd = commit && is_read;

   // ---------------------------------------------------------------------
   // Wait-state FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Wait-state FSM: next state, stall and commit
   //
   // Commit happens on the first edge where stallreq is low while en is
   // still high. Holding reset forces both outputs low so an access in
   // flight is abandoned rather than committed at the reset edge.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stallreq  = 1'b0;
      commit    = 1'b0;

      if (!resetn) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = 4'd0;
      end else if (WAIT_CYCLES == 0) begin
         state_nxt = ST_IDLE;
         commit    = data_sram_en;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (data_sram_en) begin
                  stallreq  = 1'b1;
                  cnt_nxt   = CNT_INIT;
                  state_nxt = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!data_sram_en) begin
                  // Requester flushed the access; drop it without a commit.
                  state_nxt = ST_IDLE;
               end else if (cnt != 4'd0) begin
                  stallreq = 1'b1;
                  cnt_nxt  = cnt - 4'd1;
               end else begin
                  commit    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Word array with byte write enables. No reset so it maps onto block RAM;
   // contents survive resetn.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
               mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registered read data and address error pulse. Writes keep the previous
   // read data; out-of-window reads return zero.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_sram_rdata <= 32'h0000_0000;
         addr_err        <= 1'b0;
      end else begin
         addr_err <= commit && !in_range;
         if (commit_rd) begin
            data_sram_rdata <= in_range ? mem[index] : 32'h0000_0000;
         end
      end
   end

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic        en0, stall0, err0;
   logic [3:0]  wen0;
   logic [31:0] addr0, wdata0, rdata0;

   logic        en3, stall3, err3;
   logic [3:0]  wen3;
   logic [31:0] addr3, wdata3, rdata3;

   data_sram_resp #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .resetn(resetn),
      .data_sram_en(en0), .data_sram_wen(wen0), .data_sram_addr(addr0),
      .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
      .stallreq(stall0), .addr_err(err0)
   );

   data_sram_resp #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .resetn(resetn),
      .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
      .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
      .stallreq(stall3), .addr_err(err3)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one word array and one last-rdata per DUT (0 = dut0, 1 = dut3).
   logic [31:0] mdl  [2][1024];
   logic [31:0] last [2];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb0 [$];
   exp_t sb3 [$];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wen,
                                         input logic [31:0] wdata);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (wen[i]) r[8*i +: 8] = wdata[8*i +: 8];
      return r;
   endfunction

   // One full access on the selected DUT: drive, check the stall pattern,
   // push the model's expectation at the commit edge, then pop and compare.
   task automatic access(input int d, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input string nm);
      exp_t        e, got_e;
      logic        inr, act_stall, exp_stall, act_err;
      logic [9:0]  idx;
      logic [31:0] act_rd;
      int          nstall;
      inr    = (addr[31:12] == 20'h0);
      idx    = addr[11:2];
      nstall = (d == 0) ? 0 : 3;
      @(negedge clk);
      if (d == 0) begin en0 = 1; wen0 = wen; addr0 = addr; wdata0 = wdata; end
      else        begin en3 = 1; wen3 = wen; addr3 = addr; wdata3 = wdata; end
      for (int k = 0; k <= nstall; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         exp_stall = (k < nstall);
         act_stall = (d == 0) ? stall0 : stall3;
         vectors++;
         if (act_stall !== exp_stall) begin
            miscompares++;
            $display("FAIL %s stallreq cycle %0d: got %b expected %b", nm, k, act_stall, exp_stall);
         end
         if (k < nstall) begin
            vectors++;
            if (rdata3 !== last[1]) begin
               miscompares++;
               $display("FAIL %s rdata_during_stall cycle %0d: got %h expected %h", nm, k, rdata3, last[1]);
            end
            @(posedge clk);
         end
      end
      if (wen == 4'b0000) e.rdata = inr ? mdl[d][idx] : 32'h0;
      else                e.rdata = last[d];
      if (inr && wen != 4'b0000) mdl[d][idx] = merge(mdl[d][idx], wen, wdata);
      last[d] = e.rdata;
      e.err   = !inr;
      if (d == 0) sb0.push_back(e); else sb3.push_back(e);
      @(posedge clk);
      #1;
      act_rd  = (d == 0) ? rdata0 : rdata3;
      act_err = (d == 0) ? err0 : err3;
      vectors++;
      if ((d == 0 ? sb0.size() : sb3.size()) == 0) begin
         miscompares++;
         $display("FAIL %s scoreboard_empty: got 0 entries expected 1", nm);
      end else begin
         got_e = (d == 0) ? sb0.pop_front() : sb3.pop_front();
         if (act_rd !== got_e.rdata) begin
            miscompares++;
            $display("FAIL %s rdata: got %h expected %h", nm, act_rd, got_e.rdata);
         end
         vectors++;
         if (act_err !== got_e.err) begin
            miscompares++;
            $display("FAIL %s addr_err: got %b expected %b", nm, act_err, got_e.err);
         end
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      en0 = 0; wen0 = 0; en3 = 0; wen3 = 0;
   endtask

   task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic test_reset();
      resetn = 0;
      en0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0;
      en3 = 0; wen3 = 0; addr3 = 0; wdata3 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk(rdata0, 32'h0, "reset rdata0");
      chk(rdata3, 32'h0, "reset rdata3");
      chk({31'h0, err0}, 32'h0, "reset addr_err0");
      chk({31'h0, err3}, 32'h0, "reset addr_err3");
      chk({31'h0, stall0}, 32'h0, "reset stallreq0");
      chk({31'h0, stall3}, 32'h0, "reset stallreq3");
      last[0] = 0; last[1] = 0;
      @(negedge clk);
      resetn = 1;
   endtask

   task automatic test_write_read0();
      access(0, 4'b1111, 32'h10, 32'hDEAD_BEEF, "wr0_10");
      access(0, 4'b0000, 32'h10, 32'h0, "rd0_10");
      chk(last[0], 32'hDEAD_BEEF, "model rd0_10");
      go_idle();
   endtask

   task automatic test_byte_lanes();
      access(0, 4'b1111, 32'h20, 32'h1122_3344, "lane_full");
      access(0, 4'b0100, 32'h20, 32'h00AA_0000, "lane_b2");
      access(0, 4'b0000, 32'h20, 32'h0, "lane_rd");
      chk(rdata0, 32'h11AA_3344, "lane_rd literal");
      access(0, 4'b1001, 32'h20, 32'h7700_0055, "lane_b30");
      access(0, 4'b0000, 32'h20, 32'h0, "lane_rd2");
      go_idle();
   endtask

   task automatic test_wait3();
      access(1, 4'b1111, 32'h40, 32'hCAFE_0040, "w3_wr");
      access(1, 4'b0000, 32'h40, 32'h0, "w3_rd1");
      access(1, 4'b0000, 32'h40, 32'h0, "w3_rd2");
      chk(rdata3, 32'hCAFE_0040, "w3_rd literal");
      access(1, 4'b0010, 32'h40, 32'h0000_BB00, "w3_lane");
      access(1, 4'b0000, 32'h40, 32'h0, "w3_rd3");
      go_idle();
   endtask

   task automatic test_out_of_range();
      access(0, 4'b1111, 32'h0, 32'hCAFE_F00D, "oor_pre");
      access(0, 4'b1111, 32'h1000, 32'hFFFF_FFFF, "oor_wr");
      access(0, 4'b0000, 32'h0, 32'h0, "oor_alias_rd");
      access(0, 4'b0000, 32'h1000, 32'h0, "oor_rd");
      access(0, 4'b0000, 32'h0, 32'h0, "oor_err_clear");
      go_idle();
   endtask

   task automatic test_abort();
      access(1, 4'b1111, 32'h50, 32'h1234_5678, "abort_pre");
      go_idle();
      @(negedge clk);
      en3 = 1; wen3 = 4'b1111; addr3 = 32'h50; wdata3 = 32'h9999_9999;
      #1 chk({31'h0, stall3}, 32'h1, "abort stall c1");
      @(posedge clk);
      @(negedge clk);
      en3 = 0;
      #1 chk({31'h0, stall3}, 32'h0, "abort stall c2");
      @(posedge clk);
      #1 chk({31'h0, err3}, 32'h0, "abort addr_err");
      chk(rdata3, last[1], "abort rdata");
      access(1, 4'b0000, 32'h50, 32'h0, "abort_rd");
      go_idle();
   endtask

   task automatic test_reset_mid_wait();
      access(1, 4'b1111, 32'h60, 32'hA5A5_A5A5, "rst_pre");
      access(0, 4'b0000, 32'h10, 32'h0, "rst_pre_rd0");
      go_idle();
      @(negedge clk);
      en3 = 1; wen3 = 4'b1111; addr3 = 32'h60; wdata3 = 32'h0;
      #1 chk({31'h0, stall3}, 32'h1, "rstw stall c1");
      @(posedge clk);
      @(negedge clk);
      resetn = 0;
      @(posedge clk);
      #1;
      chk(rdata3, 32'h0, "rstw rdata3");
      chk({31'h0, err3}, 32'h0, "rstw addr_err3");
      chk(rdata0, 32'h0, "rstw rdata0");
      last[0] = 0; last[1] = 0;
      @(negedge clk);
      en3 = 0;
      #1 chk({31'h0, stall3}, 32'h0, "rstw stall in reset");
      resetn = 1;
      access(1, 4'b0000, 32'h60, 32'h0, "rstw_rd");
      access(1, 4'b0000, 32'h50, 32'h0, "rstw_rd_other");
      go_idle();
   endtask

   task automatic test_back_to_back();
      access(0, 4'b1111, 32'h30, 32'h5, "b2b_wr");
      access(0, 4'b0000, 32'h30, 32'h0, "b2b_rd");
      chk(rdata0, 32'h5, "b2b literal");
      go_idle();
   endtask

   task automatic test_random();
      logic [3:0]  w;
      logic [31:0] a;
      for (int i = 0; i < 16; i++)
         access(0, 4'b1111, 32'(i * 4), $urandom, "rnd_pre");
      for (int i = 0; i < 40; i++) begin
         w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         a = 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 7) == 0) a = a | 32'h2000;
         access(0, w, a, $urandom, "rnd0");
      end
      for (int i = 0; i < 8; i++) begin
         w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         a = 32'h40 + 32'($urandom_range(0, 2) * 16);
         access(1, w, a, $urandom, "rnd3");
      end
      go_idle();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mdl[0][i] = 32'h0;
         mdl[1][i] = 32'h0;
      end
      test_reset();
      test_write_read0();
      test_byte_lanes();
      test_wait3();
      test_out_of_range();
      test_abort();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
